mem_stage: RTL and testbench

//  MEM stage of the 5-stage MIPS pipeline, fed directly by the EXE/MEM register.

---
 rtl/mem_stage_pkg.sv | 51 +++++
 rtl/mem_stage_data_ram.sv | 27 ++
 rtl/mem_stage.sv | 117 +++++++++++
 tb/tb_mem_stage.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - opcodes, load/store type encoding and decode helpers for mem_stage
package mem_stage_pkg;

   localparam logic [5:0] OP_LB  = 6'h20;
   localparam logic [5:0] OP_LH  = 6'h21;
   localparam logic [5:0] OP_LW  = 6'h23;
   localparam logic [5:0] OP_LBU = 6'h24;
   localparam logic [5:0] OP_LHU = 6'h25;
   localparam logic [5:0] OP_SB  = 6'h28;
   localparam logic [5:0] OP_SH  = 6'h29;
   localparam logic [5:0] OP_SW  = 6'h2B;

   typedef enum logic [3:0] {
      LS_NONE = 4'd0,
      LS_LB   = 4'd1,
      LS_LBU  = 4'd2,
      LS_LH   = 4'd3,
      LS_LHU  = 4'd4,
      LS_LW   = 4'd5,
      LS_SB   = 4'd6,
      LS_SH   = 4'd7,
      LS_SW   = 4'd8
   } ls_type_t;

   function automatic ls_type_t decode_op(input logic [5:0] op);
      case (op)
         OP_LB:   return LS_LB;
         OP_LH:   return LS_LH;
         OP_LW:   return LS_LW;
         OP_LBU:  return LS_LBU;
         OP_LHU:  return LS_LHU;
         OP_SB:   return LS_SB;
         OP_SH:   return LS_SH;
         OP_SW:   return LS_SW;
         default: return LS_NONE;
      endcase
   endfunction

   function automatic logic is_misaligned(input ls_type_t t, input logic [1:0] off);
      case (t)
         LS_LH, LS_LHU, LS_SH: return off[0];
         LS_LW, LS_SW:         return |off;
         default:              return 1'b0;
      endcase
   endfunction

   function automatic logic is_store(input ls_type_t t);
      return (t == LS_SB) || (t == LS_SH) || (t == LS_SW);
   endfunction

endpackage

// File: rtl/mem_stage_data_ram.sv
// rtl/mem_stage_data_ram.sv - single-port read-first synchronous RAM with byte-lane write enables
module data_ram #(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              en,
   input  logic [3:0]        we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata
);

   logic [31:0] mem [0:(1<<ADDR_W)-1];

   // Read-first: rdata returns the word as it was before this cycle's write.
   always_ff @(posedge clk) begin
      if (en) begin
         rdata <= mem[addr];
         for (int k = 0; k < 4; k++) begin
            if (we[k]) begin
               mem[addr][8*k +: 8] <= wdata[8*k +: 8];
            end
         end
      end
   end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MIPS MEM stage: data-memory access and MEM/WB register
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int ADDR_W = 10
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] instruction,
   input  logic [14:0] ctrl_msg,
   input  logic [31:0] alu,
   input  logic [31:0] B,
   input  logic        go,
   input  logic        clear,
   output logic [31:0] instruction_out,
   output logic [14:0] ctrl_msg_out,
   output logic [31:0] alu_out,
   output logic [31:0] mem_data_out,
   output logic        addr_err_out
);

   ls_type_t    ls_type;
   ls_type_t    ls_type_q;
   logic [1:0]  offset_q;
   logic        misaligned;
   logic        do_write;
   logic [3:0]  be;
   logic [3:0]  ram_we;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rdata;
   logic [31:0] shifted;
   logic [15:0] half_sel;

   assign ls_type    = decode_op(instruction[31:26]);
   assign misaligned = is_misaligned(ls_type, alu[1:0]);
   assign do_write   = rst_n && go && !clear && !misaligned && is_store(ls_type);

   // Store data is replicated across all lanes; the byte enables pick the live ones.
   always_comb begin
      be        = 4'b0000;
      ram_wdata = B;
      case (ls_type)
         LS_SB: begin
            be        = 4'b0001 << alu[1:0];
            ram_wdata = {4{B[7:0]}};
         end
         LS_SH: begin
            be        = alu[1] ? 4'b1100 : 4'b0011;
            ram_wdata = {2{B[15:0]}};
         end
         LS_SW: begin
            be        = 4'b1111;
            ram_wdata = B;
         end
         default: begin
            be        = 4'b0000;
            ram_wdata = B;
         end
      endcase
   end

   assign ram_we = do_write ? be : 4'b0000;

   data_ram #(.ADDR_W(ADDR_W)) u_data_ram (
      .clk   (clk),
      .en    (go),
      .we    (ram_we),
      .addr  (alu[ADDR_W+1:2]),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         instruction_out <= '0;
         ctrl_msg_out    <= '0;
         alu_out         <= '0;
         ls_type_q       <= LS_NONE;
         offset_q        <= '0;
         addr_err_out    <= 1'b0;
      end else if (go) begin
         if (clear) begin
            instruction_out <= '0;
            ctrl_msg_out    <= '0;
            alu_out         <= '0;
            ls_type_q       <= LS_NONE;
            offset_q        <= '0;
            addr_err_out    <= 1'b0;
         end else begin
            instruction_out <= instruction;
            ctrl_msg_out    <= ctrl_msg;
            alu_out         <= alu;
            ls_type_q       <= ls_type;
            offset_q        <= alu[1:0];
            addr_err_out    <= misaligned;
         end
      end
   end

   assign shifted  = ram_rdata >> {offset_q, 3'b000};
   assign half_sel = offset_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];

   always_comb begin
      mem_data_out = '0;
      if (!addr_err_out) begin
         case (ls_type_q)
            LS_LB:   mem_data_out = {{24{shifted[7]}}, shifted[7:0]};
            LS_LBU:  mem_data_out = {24'h0, shifted[7:0]};
            LS_LH:   mem_data_out = {{16{half_sel[15]}}, half_sel};
            LS_LHU:  mem_data_out = {16'h0, half_sel};
            LS_LW:   mem_data_out = ram_rdata;
            default: mem_data_out = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed self-checking bench for mem_stage
module tb_mem_stage;
   import mem_stage_pkg::*;

   logic        clk;
   logic        rst_n;
   logic [31:0] instruction;
   logic [14:0] ctrl_msg;
   logic [31:0] alu;
   logic [31:0] B;
   logic        go;
   logic        clear;
   logic [31:0] instruction_out;
   logic [14:0] ctrl_msg_out;
   logic [31:0] alu_out;
   logic [31:0] mem_data_out;
   logic        addr_err_out;

   int total;
   int bad;

   mem_stage #(.ADDR_W(10)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .instruction     (instruction),
      .ctrl_msg        (ctrl_msg),
      .alu             (alu),
      .B               (B),
      .go              (go),
      .clear           (clear),
      .instruction_out (instruction_out),
      .ctrl_msg_out    (ctrl_msg_out),
      .alu_out         (alu_out),
      .mem_data_out    (mem_data_out),
      .addr_err_out    (addr_err_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mk_instr(input logic [5:0] op);
      return {op, 26'h0ABCDE};
   endfunction

   function automatic logic [14:0] mk_ctrl(input logic [5:0] op);
      return {op, 9'h0A5};
   endfunction

   // Drive one cycle's inputs at negedge, then sample #1 after the following posedge.
   task automatic cyc(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic g, input logic c);
      @(negedge clk);
      instruction = mk_instr(op);
      ctrl_msg    = mk_ctrl(op);
      alu         = a;
      B           = b;
      go          = g;
      clear       = c;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      cyc(OP_SW, 32'h40, 32'h11111111, 1'b1, 1'b0);
      rst_n = 1'b0;
      cyc(OP_SW, 32'h40, 32'hDEADBEEF, 1'b1, 1'b0);
      cyc(OP_SW, 32'h40, 32'hDEADBEEF, 1'b1, 1'b0);
      total++;
      if ({instruction_out, ctrl_msg_out, alu_out, mem_data_out, addr_err_out} !== '0) begin
         bad++;
         $display("FAIL reset_outputs: instr=%h ctrl=%h alu=%h data=%h err=%b required all 0",
                  instruction_out, ctrl_msg_out, alu_out, mem_data_out, addr_err_out);
      end
      rst_n = 1'b1;
      cyc(OP_LW, 32'h40, 32'h0, 1'b1, 1'b0);
      total++;
      if (mem_data_out !== 32'h11111111) begin
         bad++;
         $display("FAIL reset_no_write: got %h required 11111111", mem_data_out);
      end
   endtask

   task automatic test_word_byte;
      cyc(OP_SW, 32'h10, 32'h8899AABB, 1'b1, 1'b0);
      total++;
      if (instruction_out !== mk_instr(OP_SW) || ctrl_msg_out !== mk_ctrl(OP_SW) ||
          alu_out !== 32'h10 || mem_data_out !== 32'h0 || addr_err_out !== 1'b0) begin
         bad++;
         $display("FAIL sw_passthru: instr=%h ctrl=%h alu=%h data=%h err=%b", instruction_out,
                  ctrl_msg_out, alu_out, mem_data_out, addr_err_out);
      end
      cyc(OP_LW, 32'h10, 32'h0, 1'b1, 1'b0);
      total++;
      if (mem_data_out !== 32'h8899AABB) begin
         bad++;
         $display("FAIL lw_0x10: got %h required 8899aabb", mem_data_out);
      end
      cyc(OP_LB, 32'h13, 32'h0, 1'b1, 1'b0);
      total++;
      if (mem_data_out !== 32'hFFFFFF88) begin
         bad++;
         $display("FAIL lb_0x13: got %h required ffffff88", mem_data_out);
      end
      cyc(OP_LBU, 32'h13, 32'h0, 1'b1, 1'b0);
      total++;
      if (mem_data_out !== 32'h00000088) begin
         bad++;
         $display("FAIL lbu_0x13: got %h required 00000088", mem_data_out);
      end
      cyc(OP_LBU, 32'h10, 32'h0, 1'b1, 1'b0);
      total++;
      if (mem_data_out !== 32'h000000BB) begin
         bad++;
         $display("FAIL lbu_0x10: got %h required 000000bb", mem_data_out);
      end
   endtask

   task automatic test_half;
      cyc(OP_SW, 32'h20, 32'h55667788, 1'b1, 1'b0);
      cyc(OP_SH, 32'h22, 32'h1234ABCD, 1'b1, 1'b0);
      cyc(OP_LW, 32'h20, 32'h0, 1'b1, 1'b0);
      total++;
      if (mem_data_out !== 32'hABCD7788) begin
         bad++;
         $display("FAIL sh_word: got %h required abcd7788", mem_data_out);
      end
      cyc(OP_LH, 32'h22, 32'h0, 1'b1, 1'b0);
      total++;
      if (mem_data_out !== 32'hFFFFABCD) begin
         bad++;
         $display("FAIL lh_0x22: got %h required ffffabcd", mem_data_out);
      end
      cyc(OP_LHU, 32'h20, 32'h0, 1'b1, 1'b0);
      total++;
      if (mem_data_out !== 32'h00007788) begin
         bad++;
         $display("FAIL lhu_0x20: got %h required 00007788", mem_data_out);
      end
   endtask

   task automatic test_misalign;
      cyc(OP_SW, 32'h30, 32'hCAFEF00D, 1'b1, 1'b0);
      cyc(OP_SW, 32'h31, 32'h01234567, 1'b1, 1'b0);
      total++;
      if (addr_err_out !== 1'b1) begin
         bad++;
         $display("FAIL sw_misalign_err: got %b required 1", addr_err_out);
      end
      cyc(OP_LW, 32'h30, 32'h0, 1'b1, 1'b0);
      total++;
      if (mem_data_out !== 32'hCAFEF00D || addr_err_out !== 1'b0) begin
         bad++;
         $display("FAIL sw_misalign_nowrite: data=%h err=%b required cafef00d 0",
                  mem_data_out, addr_err_out);
      end
      cyc(OP_LHU, 32'h31, 32'h0, 1'b1, 1'b0);
      total++;
      if (mem_data_out !== 32'h0 || addr_err_out !== 1'b1) begin
         bad++;
         $display("FAIL lhu_misalign: data=%h err=%b required 0 1", mem_data_out, addr_err_out);
      end
   endtask

   task automatic test_stall_bubble;
      cyc(OP_SW, 32'h50, 32'h00000000, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cyc(OP_SB, 32'h51, 32'h00000077, 1'b0, 1'b0);
         total++;
         if (instruction_out !== mk_instr(OP_SW) || alu_out !== 32'h50) begin
            bad++;
            $display("FAIL stall_hold_%0d: instr=%h alu=%h required %h 00000050", i,
                     instruction_out, alu_out, mk_instr(OP_SW));
         end
      end
      cyc(OP_SB, 32'h51, 32'h00000077, 1'b1, 1'b0);
      total++;
      if (instruction_out !== mk_instr(OP_SB) || alu_out !== 32'h51) begin
         bad++;
         $display("FAIL stall_release: instr=%h alu=%h required %h 00000051",
                  instruction_out, alu_out, mk_instr(OP_SB));
      end
      cyc(OP_LW, 32'h50, 32'h0, 1'b1, 1'b0);
      total++;
      if (mem_data_out !== 32'h00007700) begin
         bad++;
         $display("FAIL sb_after_stall: got %h required 00007700", mem_data_out);
      end
      cyc(OP_SW, 32'h50, 32'hFFFFFFFF, 1'b1, 1'b1);
      total++;
      if ({instruction_out, ctrl_msg_out, alu_out, mem_data_out, addr_err_out} !== '0) begin
         bad++;
         $display("FAIL bubble_outputs: instr=%h ctrl=%h alu=%h data=%h err=%b required all 0",
                  instruction_out, ctrl_msg_out, alu_out, mem_data_out, addr_err_out);
      end
      cyc(OP_LW, 32'h50, 32'h0, 1'b1, 1'b0);
      total++;
      if (mem_data_out !== 32'h00007700) begin
         bad++;
         $display("FAIL bubble_nowrite: got %h required 00007700", mem_data_out);
      end
      cyc(OP_SW, 32'h10, 32'hFFFFFFFF, 1'b0, 1'b1);
      total++;
      if (instruction_out !== mk_instr(OP_LW) || ctrl_msg_out !== mk_ctrl(OP_LW) ||
          alu_out !== 32'h50 || mem_data_out !== 32'h00007700) begin
         bad++;
         $display("FAIL clear_nogo_hold: instr=%h ctrl=%h alu=%h data=%h",
                  instruction_out, ctrl_msg_out, alu_out, mem_data_out);
      end
      cyc(OP_LW, 32'h10, 32'h0, 1'b1, 1'b0);
      total++;
      if (mem_data_out !== 32'h8899AABB) begin
         bad++;
         $display("FAIL clear_nogo_nowrite: got %h required 8899aabb", mem_data_out);
      end
   endtask

   task automatic test_wrap;
      cyc(OP_SW, 32'h1000, 32'h13579BDF, 1'b1, 1'b0);
      total++;
      if (alu_out !== 32'h1000 || addr_err_out !== 1'b0) begin
         bad++;
         $display("FAIL wrap_alu_out: alu=%h err=%b required 00001000 0", alu_out, addr_err_out);
      end
      cyc(OP_LW, 32'h0, 32'h0, 1'b1, 1'b0);
      total++;
      if (mem_data_out !== 32'h13579BDF) begin
         bad++;
         $display("FAIL wrap_lw_0: got %h required 13579bdf", mem_data_out);
      end
   endtask

   initial begin
      total       = 0;
      bad         = 0;
      rst_n       = 1'b0;
      instruction = '0;
      ctrl_msg    = '0;
      alu         = '0;
      B           = '0;
      go          = 1'b0;
      clear       = 1'b0;
      cyc(6'h00, 32'h0, 32'h0, 1'b0, 1'b0);
      cyc(6'h00, 32'h0, 32'h0, 1'b0, 1'b0);
      rst_n = 1'b1;
      test_reset();
      test_word_byte();
      test_half();
      test_misalign();
      test_stall_bubble();
      test_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
